serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial ripple-borrow subtractor, the inverse-arithmetic counterpart of the team's combinational full adder.
- Computes o_diff = i_a - i_b - i_bin, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency.
- Exchanges operands and results with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  asynchronous, active-high reset
i_start  input  1  request; sampled only in IDLE
i_a  input  WIDTH  minuend; captured when a start is accepted
i_b  input  WIDTH  subtrahend; captured when a start is accepted
i_bin  input  1  borrow-in; captured when a start is accepted
o_busy  output  1  high while in SHIFT or DONE
o_done  output  1  one-cycle pulse: result valid
o_diff  output  WIDTH  difference; held until the next result is written
o_borrow  output  1  borrow-out of the MSB; held with o_diff

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state=IDLE.
  - o_busy, o_done, o_borrow = 0; o_diff = 0.
  - Internal shift registers, borrow flip-flop and bit counter = 0.
  - Reset takes effect immediately and overrides any operation in progress; no partial result appears on o_diff.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - If i_start=1 at edge t: load a_sr<=i_a, b_sr<=i_b, br<=i_bin, cnt<=0, res_sr<=0; go to SHIFT.
  - If i_start=0: stay in IDLE; outputs hold.
- SHIFT (edges t+1 .. t+WIDTH):
  - Per edge, from LSBs a0=a_sr[0], b0=b_sr[0]:
    - d = a0 ^ b0 ^ br
    - br <= (~a0 & b0) | (~(a0 ^ b0) & br)
  - res_sr shifts right with d inserted at bit WIDTH-1; a_sr and b_sr shift right; cnt increments.
  - On the edge where cnt = WIDTH-1 (the WIDTH-th shift):
    - o_diff <= final shifted value including d.
    - o_borrow <= final br_next.
    - go to DONE.
- DONE:
  - o_done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: start accepted at edge t; o_done high in the cycle after edge t+WIDTH; a new start can be accepted at edge t+WIDTH+2 at the earliest.
- o_busy is high from the cycle after edge t through the DONE cycle inclusive.
- i_start while busy (SHIFT or DONE) is ignored: no queuing, no restart, operands not recaptured.
- Changes on i_a, i_b or i_bin after capture have no effect on the operation in progress.
- Arithmetic: {o_borrow, o_diff} equals the (WIDTH+1)-bit two's-complement value of i_a - i_b - i_bin. o_borrow=1 iff i_a < i_b + i_bin (unsigned).
- WIDTH=1: exactly one SHIFT cycle, then DONE; result equals the full subtractor truth table.
- o_diff and o_borrow change only on the SHIFT->DONE transition or on reset.

Test Plan:
- Reset then idle: hold i_start=0 for 20 cycles -> o_busy=0, o_done=0, o_diff=0x00, o_borrow=0 throughout.
- Basic (WIDTH=8): a=0x05, b=0x03, bin=0, start at edge t -> o_done pulse in the cycle after edge t+8; o_diff=0x02, o_borrow=0; o_busy high for 9 cycles.
- Underflow: a=0x00, b=0x01, bin=0 -> o_diff=0xFF, o_borrow=1.
- Borrow-in chains: a=0x80, b=0x7F, bin=1 -> o_diff=0x00, o_borrow=0. Then a=0xFF, b=0xFF, bin=1 -> o_diff=0xFF, o_borrow=1.
- Ignored start: after a=0x10, b=0x01 is accepted, pulse i_start with a=0xAA, b=0x55 at edge t+3 -> result 0x0F, borrow 0. Only one o_done pulse; the bench must issue a new start to get 0x55.
- Reset mid-operation: assert i_rst at edge t+4 of a=0x33, b=0x11 -> outputs zero immediately, state IDLE, no o_done. After release, start a=0x33, b=0x11 -> o_diff=0x22.
- Random self-check: 100 random {a, b, bin} with a reference model of a-b-bin -> all pass.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: o_diff = i_a - i_b - i_bin, LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               request, sampled only while idle
//   i_a, i_b, i_bin       operands, captured when a start is accepted
//   o_busy                high while shifting or presenting the result
//   o_done                one-cycle pulse, result valid
//   o_diff, o_borrow      result and borrow-out, held until the next result
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    // Counter is at least one bit wide so WIDTH=1 stays legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell on the current LSBs.
    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d        = a0 ^ b0 ^ br;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
        // New bit enters at the MSB; the extended vector avoids an
        // empty slice when WIDTH=1.
        res_ext  = {d, res_sr};
        res_next = res_ext[WIDTH:1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_sr   <= i_a;
                        b_sr   <= i_b;
                        br     <= i_bin;
                        cnt    <= '0;
                        res_sr <= '0;
                        o_busy <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_diff   <= res_next;
                        o_borrow <= br_next;
                        o_done   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus
// random operands checked against plain (WIDTH+1)-bit arithmetic.
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_a      (a),
        .i_b      (b),
        .i_bin    (bin),
        .o_busy   (busy),
        .o_done   (done),
        .o_diff   (diff),
        .o_borrow (borrow)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        return r;
    endfunction

    // Presents a request for one edge, then scrambles the operand inputs.
    // Returns at the first falling edge after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        @(negedge clk);
        a = x;
        b = y;
        bin = c;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
    endtask

    // Samples each falling edge until o_done. lat counts sampled busy
    // cycles since the accepting edge (first falling edge after it = 1).
    task automatic wait_done(input int lat0, output int lat,
                             output bit busy_ok, output bit held);
        logic [W-1:0] d0;
        logic         b0;
        d0 = diff;
        b0 = borrow;
        lat = lat0;
        busy_ok = busy;
        held = 1'b1;
        while (!done && lat < TMO) begin
            if (diff !== d0 || borrow !== b0) held = 1'b0;
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy !== 0 || done !== 0 || diff !== 0 || borrow !== 0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
                     busy, done, diff, borrow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 0 || done !== 0 || diff !== 0 || borrow !== 0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
                         i, busy, done, diff, borrow);
            end
        end
    endtask

    task automatic test_basic;
        int lat;
        bit bok;
        bit held;
        start_op(8'h05, 8'h03, 1'b0);
        wait_done(1, lat, bok, held);
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL basic_busy: busy dropped got 0 want 1");
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL basic_hold: result changed before done got 0 want 1");
        end
        checks++;
        if ({borrow, diff} !== 9'h002) begin
            errors++;
            $display("FAIL basic_result: got %b/%h want 0/02", borrow, diff);
        end
        @(negedge clk);
        checks++;
        if (done !== 0 || busy !== 0 || diff !== 8'h02) begin
            errors++;
            $display("FAIL basic_after: done=%b busy=%b diff=%h want 0 0 02",
                     done, busy, diff);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{8'h00, 8'h80, 8'hFF, 8'h00};
        logic [W-1:0] tb [4] = '{8'h01, 8'h7F, 8'hFF, 8'h00};
        logic         tc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W:0]   te [4] = '{9'h1FF, 9'h000, 9'h1FF, 9'h1FF};
        int lat;
        bit bok;
        bit held;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            wait_done(1, lat, bok, held);
            checks++;
            if (lat !== W + 1 || {borrow, diff} !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %b/%h lat %0d want %b/%h lat %0d",
                         i, borrow, diff, lat, te[i][W], te[i][W-1:0], W + 1);
            end
        end
    endtask

    task automatic test_ignored_start;
        int lat;
        bit bok;
        bit held;
        int extra;
        start_op(8'h10, 8'h01, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat, bok, held);
        checks++;
        if (lat !== W + 1 || {borrow, diff} !== 9'h00F) begin
            errors++;
            $display("FAIL ignored_result: got %b/%h lat %0d want 0/0f lat %0d",
                     borrow, diff, lat, W + 1);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignored_no_restart: busy/done cycles got %0d want 0", extra);
        end
        start_op(8'hAA, 8'h55, 1'b0);
        wait_done(1, lat, bok, held);
        checks++;
        if ({borrow, diff} !== 9'h055) begin
            errors++;
            $display("FAIL ignored_followup: got %b/%h want 0/55", borrow, diff);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit bok;
        bit held;
        int seen;
        start_op(8'h33, 8'h11, 1'b0);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 0 || done !== 0 || diff !== 0 || borrow !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
                     busy, done, diff, borrow);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done !== 0 || busy !== 0 || diff !== 0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: active cycles got %0d want 0", seen);
        end
        start_op(8'h33, 8'h11, 1'b0);
        wait_done(1, lat, bok, held);
        checks++;
        if (lat !== W + 1 || {borrow, diff} !== 9'h022) begin
            errors++;
            $display("FAIL reset_mid_rerun: got %b/%h lat %0d want 0/22 lat %0d",
                     borrow, diff, lat, W + 1);
        end
    endtask

    // Back-to-back random operations: each start lands at the earliest
    // accepting edge after the previous done.
    task automatic test_random;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   exp;
        int lat;
        bit bok;
        bit held;
        for (int i = 0; i < 100; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            if (i % 10 == 0) y = x;
            exp = model(x, y, c);
            start_op(x, y, c);
            wait_done(1, lat, bok, held);
            checks++;
            if (lat !== W + 1 || !bok || {borrow, diff} !== exp) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h bin=%b: got %b/%h lat %0d busy_ok %0b want %b/%h lat %0d",
                         i, x, y, c, borrow, diff, lat, bok, exp[W], exp[W-1:0], W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
